// File: rtl/io_handshake_unit.sv
// io_handshake_unit: board-side responder for the control core's INPUT, OUTPUT
// and PAUSE stalls. It debounces the confirm and continue keys and returns
// one-cycle release pulses. It also latches switch data for INPUT and register
// data for OUTPUT.
module io_handshake_unit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SW_WIDTH        = 16
) (
    input  logic                clock_i,
    input  logic                reset_ni,
    input  logic                is_input_i,
    input  logic                is_output_i,
    input  logic                is_paused_i,
    input  logic [31:0]         output_value_i,
    input  logic [SW_WIDTH-1:0] switches_i,
    input  logic                confirm_key_i,
    input  logic                continue_key_i,
    output logic                confirmation_o,
    output logic                continue_o,
    output logic [31:0]         input_data_o,
    output logic [31:0]         display_value_o,
    output logic                waiting_input_o,
    output logic                waiting_output_o
);

    // Counter wide enough for DEBOUNCE_CYCLES+1 (arming threshold).
    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    // The synchronizer's reset value is not a real observation of the key, so
    // arming waits two extra cycles for genuine samples to arrive.
    localparam logic [CW-1:0] ARM_LAST = CW'(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_PRESS,
        CONFIRM,
        WAIT_RELEASE
    } state_t;

    // Key index 0 = confirm, 1 = continue.
    logic [1:0]    keys_n;
    logic [1:0]    meta_q, sync_q, pressed_s;
    logic [1:0]    db_q, db_d, prev_q, armed_q, armed_d, press_evt;
    logic [CW-1:0] cnt_q [2];
    logic [CW-1:0] cnt_d [2];
    logic [CW-1:0] rel_q [2];
    logic [CW-1:0] rel_d [2];

    state_t        state_q;
    logic          kind_out_q;
    logic          req_held;
    logic          confirmation_q, continue_q;
    logic          waiting_input_q, waiting_output_q;
    logic [31:0]   input_data_q, display_value_q;

    assign keys_n    = {continue_key_i, confirm_key_i};
    assign pressed_s = ~sync_q;
    // A key held through reset must be seen released before it may fire.
    assign press_evt = db_q & ~prev_q & armed_q;
    assign req_held  = kind_out_q ? is_output_i : is_input_i;

    // Two-flop synchronizers, reset to the released (high) raw level.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            meta_q <= 2'b11;
            sync_q <= 2'b11;
        end else begin
            meta_q <= keys_n;
            sync_q <= meta_q;
        end
    end

    // Next-state for debounce counters, debounced levels and release arming.
    always_comb begin
        for (int k = 0; k < 2; k++) begin
            cnt_d[k]   = '0;
            db_d[k]    = db_q[k];
            armed_d[k] = armed_q[k];
            rel_d[k]   = rel_q[k];
            if (pressed_s[k] != db_q[k]) begin
                if (cnt_q[k] == CNT_LAST) db_d[k] = ~db_q[k];
                else                      cnt_d[k] = cnt_q[k] + CW'(1);
            end
            if (!armed_q[k]) begin
                if (pressed_s[k])              rel_d[k]   = '0;
                else if (rel_q[k] == ARM_LAST) armed_d[k] = 1'b1;
                else                           rel_d[k]   = rel_q[k] + CW'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            db_q    <= '0;
            prev_q  <= '0;
            armed_q <= '0;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= '0;
                rel_q[k] <= '0;
            end
        end else begin
            db_q    <= db_d;
            prev_q  <= db_q;
            armed_q <= armed_d;
            for (int k = 0; k < 2; k++) begin
                cnt_q[k] <= cnt_d[k];
                rel_q[k] <= rel_d[k];
            end
        end
    end

    // Confirm FSM with registered pulse, LEDs and data latches.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q          <= IDLE;
            kind_out_q       <= 1'b0;
            confirmation_q   <= 1'b0;
            waiting_input_q  <= 1'b0;
            waiting_output_q <= 1'b0;
            input_data_q     <= '0;
            display_value_q  <= '0;
        end else begin
            confirmation_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (is_output_i) begin
                        kind_out_q       <= 1'b1;
                        waiting_output_q <= 1'b1;
                        state_q          <= WAIT_PRESS;
                    end else if (is_input_i) begin
                        kind_out_q      <= 1'b0;
                        waiting_input_q <= 1'b1;
                        state_q         <= WAIT_PRESS;
                    end
                end
                WAIT_PRESS: begin
                    if (!req_held) begin
                        waiting_input_q  <= 1'b0;
                        waiting_output_q <= 1'b0;
                        state_q          <= IDLE;
                    end else if (press_evt[0]) begin
                        if (kind_out_q) display_value_q <= output_value_i;
                        else            input_data_q    <= 32'(switches_i);
                        confirmation_q   <= 1'b1;
                        waiting_input_q  <= 1'b0;
                        waiting_output_q <= 1'b0;
                        state_q          <= CONFIRM;
                    end
                end
                CONFIRM: begin
                    state_q <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!db_q[0]) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Continue pulse: a continue press only counts while the core is paused.
    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) continue_q <= 1'b0;
        else           continue_q <= press_evt[1] & is_paused_i;
    end

    assign confirmation_o   = confirmation_q;
    assign continue_o       = continue_q;
    assign input_data_o     = input_data_q;
    assign display_value_o  = display_value_q;
    assign waiting_input_o  = waiting_input_q;
    assign waiting_output_o = waiting_output_q;

endmodule

// File: tb/tb_io_handshake_unit.sv
// Directed bench for io_handshake_unit with DEBOUNCE_CYCLES=4.
module tb_io_handshake_unit;

    localparam int DB = 4;
    localparam int SW = 16;
    localparam int LAT = DB + 3;

    logic          clk = 1'b0;
    logic          reset_n, is_in, is_out, is_p, ck, kk;
    logic [31:0]   oval;
    logic [SW-1:0] sw;
    logic          conf, cont, w_in, w_out;
    logic [31:0]   in_data, disp;

    int cyc = 0, conf_cnt = 0, conf_cyc = 0, cont_cnt = 0, cont_cyc = 0;
    int vecs = 0, fails = 0;

    typedef struct {
        logic        in_r;
        logic        out_r;
        logic [15:0] swv;
        logic [31:0] ov;
        logic [31:0] exp_in;
        logic [31:0] exp_disp;
        logic        exp_win;
        logic        exp_wout;
    } vec_t;

    vec_t tbl [5];

    io_handshake_unit #(.DEBOUNCE_CYCLES(DB), .SW_WIDTH(SW)) dut (
        .clock_i         (clk),
        .reset_ni        (reset_n),
        .is_input_i      (is_in),
        .is_output_i     (is_out),
        .is_paused_i     (is_p),
        .output_value_i  (oval),
        .switches_i      (sw),
        .confirm_key_i   (ck),
        .continue_key_i  (kk),
        .confirmation_o  (conf),
        .continue_o      (cont),
        .input_data_o    (in_data),
        .display_value_o (disp),
        .waiting_input_o (w_in),
        .waiting_output_o(w_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (conf === 1'b1) begin conf_cnt = conf_cnt + 1; conf_cyc = cyc; end
        if (cont === 1'b1) begin cont_cnt = cont_cnt + 1; cont_cyc = cyc; end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs = vecs + 1;
        if (act !== exp) begin
            fails = fails + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic press_conf(output int t);
        @(posedge clk);
        #1;
        t  = cyc;
        ck = 1'b0;
    endtask

    task automatic press_cont(output int t);
        @(posedge clk);
        #1;
        t  = cyc;
        kk = 1'b0;
    endtask

    initial begin
        int t, c0, k0;

        tbl[0] = '{1'b0, 1'b1, 16'h1111, 32'h12345678, 32'h00000000, 32'h12345678, 1'b0, 1'b1};
        tbl[1] = '{1'b1, 1'b0, 16'hA5C3, 32'h99999999, 32'h0000A5C3, 32'h12345678, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 16'h1234, 32'hCAFEF00D, 32'h0000A5C3, 32'hCAFEF00D, 1'b0, 1'b1};
        tbl[3] = '{1'b1, 1'b0, 16'hFFFF, 32'h00000000, 32'h0000FFFF, 32'hCAFEF00D, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 32'h00000000, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1};

        // Reset held with both keys pressed and an OUTPUT request pending.
        reset_n = 1'b0; ck = 1'b0; kk = 1'b0; is_in = 1'b0; is_out = 1'b1; is_p = 1'b0;
        oval = 32'hDEADBEEF; sw = '0;
        tick(3);
        chk("rst_conf", {31'b0, conf}, 0);
        chk("rst_cont", {31'b0, cont}, 0);
        chk("rst_in_data", in_data, 0);
        chk("rst_disp", disp, 0);
        chk("rst_w_in", {31'b0, w_in}, 0);
        chk("rst_w_out", {31'b0, w_out}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        c0 = conf_cnt;
        tick(20);
        chk("rst_held_no_conf", conf_cnt - c0, 0);
        chk("rst_w_out_pending", {31'b0, w_out}, 1);
        ck = 1'b1; kk = 1'b1;
        tick(14);
        chk("rst_release_no_conf", conf_cnt - c0, 0);
        press_conf(t);
        tick(10);
        chk("rst_repress_pulses", conf_cnt - c0, 1);
        chk("rst_repress_latency", conf_cyc - t, LAT);
        chk("rst_repress_disp", disp, 32'hDEADBEEF);
        ck = 1'b1; is_out = 1'b0;
        tick(12);

        // Table of single INPUT/OUTPUT handshakes.
        for (int i = 0; i < 5; i++) begin
            is_in = tbl[i].in_r; is_out = tbl[i].out_r; sw = tbl[i].swv; oval = tbl[i].ov;
            tick(2);
            chk($sformatf("v%0d_w_in", i), {31'b0, w_in}, {31'b0, tbl[i].exp_win});
            chk($sformatf("v%0d_w_out", i), {31'b0, w_out}, {31'b0, tbl[i].exp_wout});
            c0 = conf_cnt;
            press_conf(t);
            tick(10);
            chk($sformatf("v%0d_pulses", i), conf_cnt - c0, 1);
            chk($sformatf("v%0d_latency", i), conf_cyc - t, LAT);
            chk($sformatf("v%0d_in_data", i), in_data, tbl[i].exp_in);
            chk($sformatf("v%0d_disp", i), disp, tbl[i].exp_disp);
            chk($sformatf("v%0d_leds_off", i), {30'b0, w_in, w_out}, 0);
            ck = 1'b1; is_in = 1'b0; is_out = 1'b0;
            tick(12);
        end

        // Held key must not confirm a second OUTPUT.
        is_out = 1'b1; oval = 32'hAAAA0000;
        tick(2);
        c0 = conf_cnt;
        press_conf(t);
        tick(10);
        chk("hold_first_pulse", conf_cnt - c0, 1);
        chk("hold_first_disp", disp, 32'hAAAA0000);
        is_out = 1'b0;
        tick(3);
        is_out = 1'b1; oval = 32'h55555555;
        tick(20);
        chk("hold_no_second", conf_cnt - c0, 1);
        chk("hold_disp_kept", disp, 32'hAAAA0000);
        ck = 1'b1;
        tick(12);
        chk("hold_w_out", {31'b0, w_out}, 1);
        press_conf(t);
        tick(10);
        chk("hold_second_pulse", conf_cnt - c0, 2);
        chk("hold_second_latency", conf_cyc - t, LAT);
        chk("hold_second_disp", disp, 32'h55555555);
        ck = 1'b1; is_out = 1'b0;
        tick(12);

        // Bounce: 2-cycle toggles for 20 cycles, then stable low.
        is_in = 1'b1; sw = 16'h0F0F;
        tick(2);
        c0 = conf_cnt;
        for (int i = 0; i < 10; i++) begin
            ck = (i % 2 == 1);
            tick(2);
        end
        press_conf(t);
        tick(12);
        chk("bounce_pulses", conf_cnt - c0, 1);
        chk("bounce_latency", conf_cyc - t, LAT);
        chk("bounce_in_data", in_data, 32'h00000F0F);
        ck = 1'b1; is_in = 1'b0;
        tick(12);

        // Abort: request dropped before the press.
        is_in = 1'b1; sw = 16'h7777;
        tick(2);
        chk("abort_w_in_on", {31'b0, w_in}, 1);
        is_in = 1'b0;
        tick(2);
        chk("abort_w_in_off", {31'b0, w_in}, 0);
        c0 = conf_cnt;
        press_conf(t);
        tick(10);
        chk("abort_no_pulse", conf_cnt - c0, 0);
        chk("abort_in_data", in_data, 32'h00000F0F);
        ck = 1'b1;
        tick(12);

        // PAUSE: ignored when not paused, one pulse when paused.
        k0 = cont_cnt; c0 = conf_cnt;
        press_cont(t);
        tick(10);
        chk("pause_off_no_cont", cont_cnt - k0, 0);
        kk = 1'b1;
        tick(12);
        is_p = 1'b1;
        press_cont(t);
        tick(10);
        chk("pause_cont_pulses", cont_cnt - k0, 1);
        chk("pause_cont_latency", cont_cyc - t, LAT);
        chk("pause_no_conf", conf_cnt - c0, 0);
        kk = 1'b1; is_p = 1'b0;
        tick(12);

        // Reset in the middle of a handshake drops it silently.
        is_out = 1'b1; oval = 32'h13579BDF;
        tick(2);
        c0 = conf_cnt;
        press_conf(t);
        tick(4);
        reset_n = 1'b0;
        #1;
        chk("midrst_disp", disp, 0);
        chk("midrst_w_out", {31'b0, w_out}, 0);
        is_out = 1'b0; ck = 1'b1;
        tick(2);
        @(negedge clk);
        reset_n = 1'b1;
        tick(15);
        chk("midrst_no_pulse", conf_cnt - c0, 0);
        chk("midrst_disp_after", disp, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
